// File: rtl/dispatch_pkg.sv
// Shared definitions for the 4-to-16 request dispatcher: state encoding,
// line count and index width.
package dispatch_pkg;

    localparam int NLINES = 16;
    localparam int IDXW   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Width of the acknowledge-wait counter; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dispatch4to16_decode.sv
// Purely combinational index to one-hot decoder used to build the
// request-line pattern before it is registered.
module decode4to16
    import dispatch_pkg::*;
(
    input  logic [IDXW-1:0]   idx,
    output logic [NLINES-1:0] onehot
);

    localparam logic [NLINES-1:0] ONE = NLINES'(1);

    assign onehot = ONE << idx;

endmodule

// File: rtl/dispatch4to16.sv
// Issue-side request dispatcher: takes a line index over valid/ready, drives
// the matching request line and runs a four-phase req/ack with a timeout.
module dispatch4to16
    import dispatch_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [IDXW-1:0]   in,
    output logic              in_ready,
    output logic [NLINES-1:0] out,
    input  logic [NLINES-1:0] ack,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LAST    = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam bit            TO_ON   = (TIMEOUT != 0);

    state_t              state, state_n;
    logic [IDXW-1:0]     idx, idx_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [NLINES-1:0]   out_n;
    logic                busy_n, done_n, timeout_n;
    logic [IDXW-1:0]     dec_sel;
    logic [NLINES-1:0]   dec_onehot;
    logic                sel_ack;

    // While idle the decoder looks at the offered index so the one-hot value
    // is ready to register on the handshake edge; otherwise it holds idx.
    assign dec_sel  = (state == IDLE) ? in : idx;
    assign sel_ack  = ack[idx];
    assign in_ready = enable && (state == IDLE);

    decode4to16 u_decode (
        .idx    (dec_sel),
        .onehot (dec_onehot)
    );

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        cnt_n     = cnt;
        out_n     = '0;
        done_n    = 1'b0;
        timeout_n = 1'b0;

        if (!enable) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        idx_n   = in;
                        cnt_n   = '0;
                        state_n = REQ;
                        out_n   = dec_onehot;
                    end
                end
                // An ack on the last allowed cycle still counts as success.
                REQ: begin
                    if (sel_ack) begin
                        state_n = RELEASE;
                        done_n  = 1'b1;
                    end else if (TO_ON && (cnt == LAST)) begin
                        state_n   = IDLE;
                        timeout_n = 1'b1;
                    end else begin
                        if (cnt != CNT_MAX) begin
                            cnt_n = cnt + 1'b1;
                        end
                        out_n = dec_onehot;
                    end
                end
                RELEASE: begin
                    if (!sel_ack) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            out     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            cnt     <= cnt_n;
            out     <= out_n;
            busy    <= busy_n;
            done    <= done_n;
            timeout <= timeout_n;
        end
    end

endmodule
